mac_secuencial: RTL and testbench

MAC_SECUENCIAL -- requirements
Module: mac_secuencial

---
 rtl/mac_secuencial.sv | 132 +++++++++++++
 tb/tb_mac_secuencial.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mac_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : mac_secuencial
// Purpose  : Signed sequential multiply-accumulate using a radix-2 shift-add
//            multiplier (N cycles per product) and a 2N-bit accumulator.
//            Optional macro MAC_SECUENCIAL_SAT_ACC_EN: saturating accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mac_secuencial #(
    parameter int N = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Clr_Acc,
    input  logic [N-1:0]     Dato_A,
    input  logic [N-1:0]     Dato_B,
    output logic [2*N-1:0]   Datos_Sum,
    output logic             Listo,
    output logic             Ocupado
);

    localparam int              c_CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(N - 1);
    localparam logic [N-1:0]    c_ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0]  c_ONE_2N  = {{(2*N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULT  = 2'd1,
        S_ACUM  = 2'd2,
        S_LISTO = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [N-1:0]         r_mcand;
    logic [2*N-1:0]       r_prod;
    logic                 r_sign;
    logic                 r_clr;
    logic [2*N-1:0]       r_sum;

    logic [N-1:0]         w_mag_a;
    logic [N-1:0]         w_mag_b;
    logic [N:0]           w_step;
    logic [2*N-1:0]       w_prod_s;
    logic [2*N-1:0]       w_base;
    logic [2*N-1:0]       w_sum;
    logic [2*N-1:0]       w_acc_next;

    // Two's-complement negation of the most negative value yields 2^(N-1),
    // which is exactly the correct unsigned magnitude.
    assign w_mag_a = Dato_A[N-1] ? (~Dato_A + c_ONE_N) : Dato_A;
    assign w_mag_b = Dato_B[N-1] ? (~Dato_B + c_ONE_N) : Dato_B;

    // Multiplier sits in the low half of r_prod and is consumed LSB first
    // while partial sums enter the high half and everything shifts right.
    assign w_step   = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

    assign w_prod_s = r_sign ? (~r_prod + c_ONE_2N) : r_prod;
    assign w_base   = r_clr ? '0 : r_sum;
    assign w_sum    = w_base + w_prod_s;

`ifdef MAC_SECUENCIAL_SAT_ACC_EN
    logic w_ovf;
    assign w_ovf      = (w_base[2*N-1] == w_prod_s[2*N-1]) && (w_sum[2*N-1] != w_base[2*N-1]);
    assign w_acc_next = !w_ovf        ? w_sum :
                        w_base[2*N-1] ? {1'b1, {(2*N-1){1'b0}}} :
                                        {1'b0, {(2*N-1){1'b1}}};
`else
    assign w_acc_next = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_state_next = S_MULT;
            S_MULT:  if (r_cnt == c_CNT_LAST) w_state_next = S_ACUM;
            S_ACUM:  w_state_next = S_LISTO;
            S_LISTO: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_sign  <= 1'b0;
            r_clr   <= 1'b0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_mcand <= w_mag_a;
                        r_prod  <= {{N{1'b0}}, w_mag_b};
                        r_sign  <= Dato_A[N-1] ^ Dato_B[N-1];
                        r_clr   <= Clr_Acc;
                        r_cnt   <= '0;
                    end else if (Clr_Acc) begin
                        r_sum   <= '0;
                    end
                end
                S_MULT: begin
                    r_prod <= {w_step, r_prod[N-1:1]};
                    r_cnt  <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
                end
                S_ACUM: begin
                    r_sum <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign Datos_Sum = r_sum;
    assign Listo     = (r_state == S_LISTO);
    assign Ocupado   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mac_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_secuencial
// Purpose  : Directed self-checking bench for mac_secuencial at N=25.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_secuencial;

    localparam int N = 25;

    logic             clk = 1'b0;
    logic             reset;
    logic             Start;
    logic             Clr_Acc;
    logic [N-1:0]     Dato_A;
    logic [N-1:0]     Dato_B;
    logic [2*N-1:0]   Datos_Sum;
    logic             Listo;
    logic             Ocupado;

    int vectors     = 0;
    int miscompares = 0;

    mac_secuencial #(.N(N)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Clr_Acc   (Clr_Acc),
        .Dato_A    (Dato_A),
        .Dato_B    (Dato_B),
        .Datos_Sum (Datos_Sum),
        .Listo     (Listo),
        .Ocupado   (Ocupado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start is driven just after edge k and sampled at the following edge;
    // Listo is expected 27 edges after k and Ocupado for 27 cycles.
    task automatic do_op(input string tag, input logic clr, input logic signed [N-1:0] a,
                         input logic signed [N-1:0] b, input logic [2*N-1:0] exp, input bit noise);
        int lat, busy, listos;
        logic [2*N-1:0] got;
        lat = -1; busy = 0; listos = 0; got = '0;
        @(posedge clk); #1;
        Start = 1'b1; Clr_Acc = clr; Dato_A = a; Dato_B = b;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            Dato_A = N'($urandom); Dato_B = N'($urandom);
            if (noise && (e == 5 || e == 26)) begin
                Start = 1'b1; Clr_Acc = 1'b1;
            end else begin
                Start = 1'b0; Clr_Acc = 1'b0;
            end
            @(negedge clk);
            if (Ocupado) busy++;
            if (Listo) begin
                listos++;
                if (lat < 0) begin
                    lat = e;
                    got = Datos_Sum;
                end
            end
        end
        check({tag, "_latency"}, (2*N)'(lat), (2*N)'(27));
        check({tag, "_busy"},    (2*N)'(busy), (2*N)'(27));
        check({tag, "_listos"},  (2*N)'(listos), (2*N)'(1));
        check({tag, "_sum"},     got, exp);
        check({tag, "_hold"},    Datos_Sum, exp);
    endtask

    initial begin
        logic [2*N-1:0] exp_big;
        int listos;
        reset = 1'b1; Start = 1'b0; Clr_Acc = 1'b0; Dato_A = '0; Dato_B = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_sum",     Datos_Sum, '0);
        check("rst_listo",   {49'd0, Listo}, '0);
        check("rst_ocupado", {49'd0, Ocupado}, '0);

        do_op("clr_3x5",   1'b1, 25'sd3,  25'sd5, 50'd15, 1'b0);
        do_op("acc_m1x1",  1'b0, -25'sd1, 25'sd1, 50'd14, 1'b0);
        do_op("clr_m1x1",  1'b1, -25'sd1, 25'sd1, {50{1'b1}}, 1'b0);
        do_op("clr_m7xm9", 1'b1, -25'sd7, -25'sd9, 50'd63, 1'b0);
        do_op("acc_12xm4", 1'b0, 25'sd12, -25'sd4, 50'd15, 1'b0);

        do_op("clr_min2",  1'b1, {1'b1, 24'd0}, {1'b1, 24'd0}, 50'd1 << 48, 1'b0);
`ifdef MAC_SECUENCIAL_SAT_ACC_EN
        exp_big = {1'b0, {49{1'b1}}};
`else
        exp_big = {1'b1, 49'd0};
`endif
        do_op("acc_min2",  1'b0, {1'b1, 24'd0}, {1'b1, 24'd0}, exp_big, 1'b0);

        do_op("noise_6x7", 1'b1, 25'sd6, 25'sd7, 50'd42, 1'b1);

        // Reset asserted mid-MULT together with Start: must abort to IDLE.
        @(posedge clk); #1;
        Start = 1'b1; Clr_Acc = 1'b0; Dato_A = 25'sd9; Dato_B = 25'sd9;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1; Start = 1'b1; Clr_Acc = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; Start = 1'b0; Clr_Acc = 1'b0;
        @(negedge clk);
        check("midrst_sum",     Datos_Sum, '0);
        check("midrst_ocupado", {49'd0, Ocupado}, '0);
        listos = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (Listo) listos++;
        end
        check("midrst_nolisto", (2*N)'(listos), '0);

        // Clear-only in IDLE after loading a nonzero sum.
        do_op("pre_clr",   1'b1, 25'sd100, -25'sd3, -50'sd300, 1'b0);
        @(posedge clk); #1;
        Clr_Acc = 1'b1;
        @(posedge clk); #1;
        Clr_Acc = 1'b0;
        @(negedge clk);
        check("clronly_sum",     Datos_Sum, '0);
        check("clronly_listo",   {49'd0, Listo}, '0);
        check("clronly_ocupado", {49'd0, Ocupado}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
